// File: rtl/section_min_max_detector.sv
// Section min/max detector: converts a stream of signed two's-complement
// samples to offset binary and reports one {min, max} pair per fixed-length
// section over a valid/ready handshake.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   clear               synchronous abort of partial section and pending result
//   i_valid/i_ready     sample handshake (i_ready registered)
//   i_sample            signed two's-complement sample
//   o_valid/o_ready     result handshake (o_valid registered)
//   o_min_value         section minimum, offset binary
//   o_max_value         section maximum, offset binary
module section_min_max_detector #(
  parameter int unsigned width          = 16,
  parameter int unsigned section_length = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [width-1:0] i_sample,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [width-1:0] o_min_value,
  output logic [width-1:0] o_max_value
);

  localparam int unsigned cw = (section_length > 1) ? $clog2(section_length) : 1;
  localparam logic [cw-1:0] last_count = cw'(section_length - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic [width-1:0] acc_min;
  logic [width-1:0] acc_max;
  logic [cw-1:0]    count;

  logic [width-1:0] u;
  logic [width-1:0] nmin;
  logic [width-1:0] nmax;
  logic             accept;
  logic             last;
  logic             slot_free;

  // Offset-binary view of the sample and the running extremes including it
  always_comb begin
    u         = {~i_sample[width-1], i_sample[width-2:0]};
    nmin      = (u < acc_min) ? u : acc_min;
    nmax      = (u > acc_max) ? u : acc_max;
    accept    = i_valid && i_ready;
    last      = (count == last_count);
    slot_free = !o_valid || o_ready;
  end

  // Accumulation, section hand-off and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ACCUM;
      i_ready     <= 1'b1;
      o_valid     <= 1'b0;
      o_min_value <= '0;
      o_max_value <= '0;
      acc_min     <= '1;
      acc_max     <= '0;
      count       <= '0;
    end else begin
      // Consumed result drops o_valid unless a new pair loads below
      if (o_valid && o_ready) o_valid <= 1'b0;

      if (clear) begin
        // Output register left alone so an already-valid pair still drains
        state   <= ACCUM;
        i_ready <= 1'b1;
        acc_min <= '1;
        acc_max <= '0;
        count   <= '0;
      end else begin
        case (state)
          ACCUM: begin
            if (accept) begin
              if (!last) begin
                acc_min <= nmin;
                acc_max <= nmax;
                count   <= count + cw'(1);
              end else if (slot_free) begin
                o_min_value <= nmin;
                o_max_value <= nmax;
                o_valid     <= 1'b1;
                acc_min     <= '1;
                acc_max     <= '0;
                count       <= '0;
              end else begin
                // Park the finished section in the accumulators until the
                // output slot drains
                acc_min <= nmin;
                acc_max <= nmax;
                count   <= '0;
                i_ready <= 1'b0;
                state   <= FULL;
              end
            end
          end
          FULL: begin
            if (o_ready) begin
              o_min_value <= acc_min;
              o_max_value <= acc_max;
              o_valid     <= 1'b1;
              acc_min     <= '1;
              acc_max     <= '0;
              i_ready     <= 1'b1;
              state       <= ACCUM;
            end
          end
          default: begin
            state   <= ACCUM;
            i_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
